// File: rtl/mbscore_int_sched_pkg.sv
// Shared MBScore interrupt constants: source ids, handler addresses and the id->address lookup.
package mbscore_int_sched_pkg;

  localparam int unsigned ADDR_WIDTH = 32;

  localparam int unsigned INT_ID_SYSCALL  = 0;
  localparam int unsigned INT_ID_KEYBOARD = 1;
  localparam int unsigned INT_ID_MOUSE    = 2;
  localparam int unsigned INT_ID_UART     = 3;
  localparam int unsigned INT_ID_STORAGE  = 4;
  localparam int unsigned INT_ID_ETHERNET = 5;
  localparam int unsigned INT_ID_CF       = 6;

  localparam logic [ADDR_WIDTH-1:0] INT_SYSCALL_ADDR  = 32'h0000_0100;
  localparam logic [ADDR_WIDTH-1:0] INT_KEYBOARD_ADDR = 32'h0000_0120;
  localparam logic [ADDR_WIDTH-1:0] INT_MOUSE_ADDR    = 32'h0000_0140;
  localparam logic [ADDR_WIDTH-1:0] INT_UART_ADDR     = 32'h0000_0160;
  localparam logic [ADDR_WIDTH-1:0] INT_STORAGE_ADDR  = 32'h0000_0180;
  localparam logic [ADDR_WIDTH-1:0] INT_ETHERNET_ADDR = 32'h0000_01A0;
  localparam logic [ADDR_WIDTH-1:0] INT_CF_ADDR       = 32'h0000_01C0;

  function automatic logic [ADDR_WIDTH-1:0] int_addr_of(input int unsigned id);
    logic [ADDR_WIDTH-1:0] addr;
    case (id)
      INT_ID_SYSCALL:  addr = INT_SYSCALL_ADDR;
      INT_ID_KEYBOARD: addr = INT_KEYBOARD_ADDR;
      INT_ID_MOUSE:    addr = INT_MOUSE_ADDR;
      INT_ID_UART:     addr = INT_UART_ADDR;
      INT_ID_STORAGE:  addr = INT_STORAGE_ADDR;
      INT_ID_ETHERNET: addr = INT_ETHERNET_ADDR;
      INT_ID_CF:       addr = INT_CF_ADDR;
      default:         addr = '0;
    endcase
    return addr;
  endfunction

endpackage

// File: rtl/mbscore_prio_enc.sv
// Combinational fixed-priority encoder; the lowest set index wins.
module mbscore_prio_enc #(
  parameter int unsigned N_SRC = 7,
  parameter int unsigned ID_W  = 3
) (
  input  logic [N_SRC-1:0] req,
  output logic             valid,
  output logic [ID_W-1:0]  id
);

  always_comb begin
    valid = |req;
    id    = '0;
    // Scan downwards so the lowest index is the last to assign.
    for (int i = int'(N_SRC) - 1; i >= 0; i--) begin
      if (req[i]) id = ID_W'(i);
    end
  end

endmodule

// File: rtl/mbscore_int_sched.sv
// Interrupt scheduler: edge capture into pending, masking, priority selection and a
// req/ack/eoi handshake to the core with no nesting.
module mbscore_int_sched #(
  parameter int unsigned N_SRC      = 7,
  parameter int unsigned ID_W       = 3,
  parameter int unsigned ADDR_WIDTH = mbscore_int_sched_pkg::ADDR_WIDTH,
  parameter int unsigned CNT_W      = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_SRC-1:0]      irq_src,
  input  logic                  int_en_n,
  input  logic                  mask_we,
  input  logic [N_SRC-1:0]      mask_wdata,
  output logic [N_SRC-1:0]      mask,
  output logic [N_SRC-1:0]      pending,
  output logic                  int_req,
  output logic [ID_W-1:0]       int_id,
  output logic [ADDR_WIDTH-1:0] int_addr,
  input  logic                  int_ack,
  input  logic                  eoi,
  output logic                  in_service,
  output logic [CNT_W-1:0]      lost_cnt
);
  import mbscore_int_sched_pkg::*;

  typedef enum logic [1:0] {StIdle, StReq, StService} state_e;

  state_e                state_q, state_d;
  logic [N_SRC-1:0]      irq_q, pending_q, pending_d, mask_q, edge_det, clr_vec;
  logic [ID_W-1:0]       int_id_q, int_id_d;
  logic [ADDR_WIDTH-1:0] int_addr_q, int_addr_d;
  logic [CNT_W-1:0]      lost_cnt_q;
  logic                  ack_clr, enc_valid;
  logic [ID_W-1:0]       enc_id;

  mbscore_prio_enc #(
    .N_SRC (N_SRC),
    .ID_W  (ID_W)
  ) u_prio_enc (
    .req   (pending_q & ~mask_q),
    .valid (enc_valid),
    .id    (enc_id)
  );

  assign edge_det = irq_src & ~irq_q;
  assign clr_vec  = ack_clr ? (N_SRC'(1) << int_id_q) : '0;
  // Set has priority over the ack clear.
  assign pending_d = (pending_q & ~clr_vec) | edge_det;

  always_comb begin
    state_d    = state_q;
    int_id_d   = int_id_q;
    int_addr_d = int_addr_q;
    ack_clr    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (enc_valid && !int_en_n) begin
          state_d    = StReq;
          int_id_d   = enc_id;
          int_addr_d = ADDR_WIDTH'(int_addr_of(int'(enc_id)));
        end
      end
      StReq: begin
        if (int_ack) begin
          state_d    = StService;
          int_id_d   = '0;
          int_addr_d = '0;
          ack_clr    = 1'b1;
        end
      end
      StService: begin
        if (eoi) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      int_id_q   <= '0;
      int_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      int_id_q   <= int_id_d;
      int_addr_q <= int_addr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      irq_q     <= '0;
      pending_q <= '0;
    end else begin
      irq_q     <= irq_src;
      pending_q <= pending_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mask_q <= '1;
    end else if (mask_we) begin
      mask_q <= mask_wdata;
    end
  end

  // Several lost edges in one cycle count once.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lost_cnt_q <= '0;
    end else if (|(edge_det & pending_q) && (lost_cnt_q != '1)) begin
      lost_cnt_q <= lost_cnt_q + CNT_W'(1);
    end
  end

  assign mask       = mask_q;
  assign pending    = pending_q;
  assign int_req    = (state_q == StReq);
  assign int_id     = int_id_q;
  assign int_addr   = int_addr_q;
  assign in_service = (state_q == StService);
  assign lost_cnt   = lost_cnt_q;

endmodule
